// File: rtl/team_06_wb_master.sv
// Single-transfer Wishbone classic initiator: one command in via valid/ready,
// one bus cycle with ACK/timeout, one-cycle response pulse out.
module team_06_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  logic [1:0]      state;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      STB_O     <= 1'b0;
      CYC_O     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ADR_O     <= cmd_adr;
            DAT_O     <= cmd_dat;
            SEL_O     <= cmd_sel;
            WE_O      <= cmd_we;
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            state     <= BUS;
          end
        end
        BUS: begin
          // ACK takes priority over a timeout landing on the same edge.
          if (ACK_I) begin
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            WE_O      <= 1'b0;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_dat   <= WE_O ? '0 : DAT_I;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            WE_O      <= 1'b0;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_dat   <= '0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
